key_event_ctrl: RTL and testbench

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/key_event_ctrl_pkg.sv | 14 +
 rtl/key_event_ctrl_rr_arbiter4.sv | 30 +++
 rtl/key_event_ctrl.sv | 109 ++++++++++
 tb/tb_key_event_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/key_event_ctrl_pkg.sv
// Shared types for the key event controller: FSM state encoding
// and the number of keys serviced.
package key_event_ctrl_pkg;

   localparam int NUM_KEYS = 4;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_TIME     = 2'd1,
      S_EMIT     = 2'd2,
      S_WAIT_REL = 2'd3
   } state_t;

endpackage

// File: rtl/key_event_ctrl_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter.
// Ports: req[3:0] requests, last[1:0] previous grant,
//        grant[1:0] chosen index, any = some request present.
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [1:0] grant,
   output logic       any
);

   logic [1:0] idx;
   logic       found;

   // Search starts at last+1 and wraps; last itself is checked last.
   always_comb begin
      grant = last;
      found = 1'b0;
      idx   = last;
      for (int k = 1; k <= 4; k++) begin
         idx = last + 2'(k);
         if (!found && req[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/key_event_ctrl.sv
// Turns debounced active-low key presses into short/long press
// events delivered over a valid/ready handshake.
// Ports: clk, rst (async, high), io_keys[3:0] (0 = pressed),
//        io_evt_valid/io_evt_ready handshake,
//        io_evt_key[1:0] key index, io_evt_long long-press flag.
module key_event_ctrl
   import key_event_ctrl_pkg::*;
#(
   parameter int unsigned            CNT_W    = 26,
   parameter logic [CNT_W-1:0]       LONG_CNT = 26'd50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] io_keys,
   output logic       io_evt_valid,
   input  logic       io_evt_ready,
   output logic [1:0] io_evt_key,
   output logic       io_evt_long
);

   localparam logic [CNT_W-1:0] LAST_CNT = LONG_CNT - CNT_W'(1);

   state_t                state;
   state_t                state_nx;
   logic [NUM_KEYS-1:0]   prev;
   logic [NUM_KEYS-1:0]   pend;
   logic [NUM_KEYS-1:0]   press;
   logic [NUM_KEYS-1:0]   clr;
   logic                  armed;
   logic [1:0]            last;
   logic [1:0]            grant;
   logic                  any;
   logic [CNT_W-1:0]      timer;
   logic                  rel;
   logic                  do_grant;
   logic                  do_emit;

   // Edges are masked for the first cycle out of reset so a key
   // held through reset is not seen as a fresh press.
   assign press = armed ? (prev & ~io_keys) : '0;
   assign rel   = io_keys[last];

   rr_arbiter4 u_arb (
      .req   (pend),
      .last  (last),
      .grant (grant),
      .any   (any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         io_evt_valid <= 1'b0;
      end else begin
         state        <= state_nx;
         io_evt_valid <= (state_nx == S_EMIT);
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:
            if (any) state_nx = S_TIME;
         S_TIME:
            if (rel || timer == LAST_CNT) state_nx = S_EMIT;
         S_EMIT:
            if (io_evt_ready)
               state_nx = io_evt_long ? S_WAIT_REL : S_IDLE;
         S_WAIT_REL:
            if (rel) state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      do_grant = (state == S_IDLE) && any;
      do_emit  = (state == S_TIME) && (state_nx == S_EMIT);
      clr      = do_grant ? (NUM_KEYS'(1) << grant) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed       <= 1'b0;
         prev        <= 4'hF;
         pend        <= '0;
         last        <= 2'd3;
         timer       <= '0;
         io_evt_key  <= 2'd0;
         io_evt_long <= 1'b0;
      end else begin
         armed <= 1'b1;
         prev  <= io_keys;
         // A press landing on the key being granted stays pending.
         pend  <= (pend & ~clr) | press;
         if (do_grant) begin
            last  <= grant;
            timer <= '0;
         end else if (state == S_TIME) begin
            timer <= timer + CNT_W'(1);
         end
         // Release wins over reaching the long-press count.
         if (do_emit) begin
            io_evt_key  <= last;
            io_evt_long <= ~rel;
         end
      end
   end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Scoreboard bench for key_event_ctrl with LONG_CNT = 100.
module tb_key_event_ctrl;

   typedef struct packed {
      logic [1:0] key;
      logic       lng;
   } evt_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] io_keys = 4'hF;
   logic       io_evt_ready = 1'b0;
   logic       io_evt_valid;
   logic [1:0] io_evt_key;
   logic       io_evt_long;

   int   checks = 0;
   int   errors = 0;
   evt_t exp_q[$];

   always #10 clk = ~clk;

   key_event_ctrl #(
      .CNT_W    (26),
      .LONG_CNT (26'd100)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .io_keys      (io_keys),
      .io_evt_valid (io_evt_valid),
      .io_evt_ready (io_evt_ready),
      .io_evt_key   (io_evt_key),
      .io_evt_long  (io_evt_long)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act,
                        input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, req);
      end
   endtask

   task automatic expect_evt(input logic [1:0] k, input logic l);
      evt_t e;
      e.key = k;
      e.lng = l;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || io_evt_valid) && n < 600) begin
         tick(1);
         n++;
      end
      check({name, "_drain"},
            int'(exp_q.size() != 0 || io_evt_valid), 0);
      tick(3);
   endtask

   // Monitor: pops on every handshake, checks hold stability.
   initial begin
      bit         hold;
      logic [1:0] hk;
      logic       hl;
      evt_t       e;
      hold = 1'b0;
      hk   = '0;
      hl   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 1'b0;
         end else if (io_evt_valid) begin
            if (hold) begin
               check("stable_key", io_evt_key, hk);
               check("stable_long", io_evt_long, hl);
            end
            if (io_evt_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_event key %0d long %0d required none",
                           io_evt_key, io_evt_long);
               end else begin
                  e = exp_q.pop_front();
                  check("evt_key", io_evt_key, e.key);
                  check("evt_long", io_evt_long, e.lng);
               end
               hold = 1'b0;
            end else begin
               hold = 1'b1;
               hk   = io_evt_key;
               hl   = io_evt_long;
            end
         end else begin
            hold = 1'b0;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end

   initial begin
      int n;
      tick(3);
      check("rst_valid", io_evt_valid, 0);
      check("rst_key", io_evt_key, 0);
      check("rst_long", io_evt_long, 0);
      rst = 1'b0;
      tick(2);
      io_evt_ready = 1'b1;

      // keys 0 and 3 together: key 0 first after reset
      expect_evt(2'd0, 1'b0);
      expect_evt(2'd3, 1'b0);
      io_keys = 4'b0110;
      tick(5);
      io_keys = 4'hF;
      drain("simul");

      // short press key 2
      expect_evt(2'd2, 1'b0);
      io_keys[2] = 1'b0;
      tick(10);
      io_keys[2] = 1'b1;
      drain("short");

      // long press key 1, latency from press drive
      expect_evt(2'd1, 1'b1);
      io_keys[1] = 1'b0;
      tick(101);
      check("long_early", io_evt_valid, 0);
      tick(1);
      check("long_latency", io_evt_valid, 1);
      tick(198);
      io_keys[1] = 1'b1;
      drain("long");

      // backpressure
      io_evt_ready = 1'b0;
      expect_evt(2'd0, 1'b0);
      io_keys[0] = 1'b0;
      tick(5);
      io_keys[0] = 1'b1;
      n = 0;
      while (!io_evt_valid && n < 50) begin
         tick(1);
         n++;
      end
      check("bp_valid_rise", io_evt_valid, 1);
      repeat (50) begin
         tick(1);
         check("bp_hold", io_evt_valid, 1);
      end
      io_evt_ready = 1'b1;
      drain("bp");

      // release sampled at timer 99 -> short
      expect_evt(2'd3, 1'b0);
      io_keys[3] = 1'b0;
      tick(101);
      io_keys[3] = 1'b1;
      drain("bound_short");

      // one cycle longer -> long
      expect_evt(2'd3, 1'b1);
      io_keys[3] = 1'b0;
      tick(102);
      io_keys[3] = 1'b1;
      drain("bound_long");

      // reset mid-TIME, key held through deassert
      io_keys[2] = 1'b0;
      tick(20);
      rst = 1'b1;
      #1;
      check("midrst_valid", io_evt_valid, 0);
      check("midrst_key", io_evt_key, 0);
      check("midrst_long", io_evt_long, 0);
      tick(5);
      rst = 1'b0;
      tick(20);
      check("post_rst_valid", io_evt_valid, 0);
      io_keys[2] = 1'b1;
      tick(3);
      expect_evt(2'd2, 1'b0);
      io_keys[2] = 1'b0;
      tick(8);
      io_keys[2] = 1'b1;
      drain("fresh");

      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
